fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, presents it to program memory and
// latches the returned word into the IF/ID pipeline register.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Target_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] IF_ID_PC_o,
    output logic [DATA_WIDTH-1:0] IF_ID_PC_Plus4_o,
    output logic [DATA_WIDTH-1:0] IF_ID_Instruction_o,
    output logic                  IF_ID_Valid_o,
    output logic                  Misaligned_o,
    output logic [31:0]           Fetch_Count_o
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = '0;

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_if_id_pc;
    logic [DATA_WIDTH-1:0] r_if_id_pc_plus4;
    logic [DATA_WIDTH-1:0] r_if_id_instr;
    logic                  r_if_id_valid;
    logic                  r_misaligned;
    logic [31:0]           r_fetch_count;

    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_pc_next;
    logic [DATA_WIDTH-1:0] w_if_id_pc_next;
    logic [DATA_WIDTH-1:0] w_if_id_pc_plus4_next;
    logic [DATA_WIDTH-1:0] w_if_id_instr_next;
    logic                  w_if_id_valid_next;
    logic                  w_misaligned_next;
    logic [31:0]           w_fetch_count_next;

    assign w_pc_plus4 = r_pc + PC_STEP;

    // Next-state selection: redirect flushes and beats stall; stall holds everything.
    always_comb begin
        w_pc_next             = r_pc;
        w_if_id_pc_next       = r_if_id_pc;
        w_if_id_pc_plus4_next = r_if_id_pc_plus4;
        w_if_id_instr_next    = r_if_id_instr;
        w_if_id_valid_next    = r_if_id_valid;
        w_fetch_count_next    = r_fetch_count;
        w_misaligned_next     = 1'b0;
        if (Redirect_i) begin
            w_pc_next             = {Target_i[DATA_WIDTH-1:2], 2'b00};
            w_if_id_pc_next       = ZERO_W;
            w_if_id_pc_plus4_next = ZERO_W;
            w_if_id_instr_next    = NOP_INSTR;
            w_if_id_valid_next    = 1'b0;
            w_misaligned_next     = (Target_i[1:0] != 2'b00);
        end else if (!Stall_i) begin
            w_pc_next             = w_pc_plus4;
            w_if_id_pc_next       = r_pc;
            w_if_id_pc_plus4_next = w_pc_plus4;
            w_if_id_instr_next    = Instruction_i;
            w_if_id_valid_next    = 1'b1;
            w_fetch_count_next    = r_fetch_count + 32'd1;
        end else begin
            w_pc_next             = r_pc;
        end
    end

    // Pipeline state registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc             <= PC_RESET;
            r_if_id_pc       <= ZERO_W;
            r_if_id_pc_plus4 <= ZERO_W;
            r_if_id_instr    <= NOP_INSTR;
            r_if_id_valid    <= 1'b0;
            r_misaligned     <= 1'b0;
            r_fetch_count    <= 32'd0;
        end else begin
            r_pc             <= w_pc_next;
            r_if_id_pc       <= w_if_id_pc_next;
            r_if_id_pc_plus4 <= w_if_id_pc_plus4_next;
            r_if_id_instr    <= w_if_id_instr_next;
            r_if_id_valid    <= w_if_id_valid_next;
            r_misaligned     <= w_misaligned_next;
            r_fetch_count    <= w_fetch_count_next;
        end
    end

    assign PC_o                = r_pc;
    assign IF_ID_PC_o          = r_if_id_pc;
    assign IF_ID_PC_Plus4_o    = r_if_id_pc_plus4;
    assign IF_ID_Instruction_o = r_if_id_instr;
    assign IF_ID_Valid_o       = r_if_id_valid;
    assign Misaligned_o        = r_misaligned;
    assign Fetch_Count_o       = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; program memory returns address ^ 0xA5A5_0000.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall_i;
    logic        Redirect_i;
    logic [31:0] Target_i;
    logic [31:0] Instruction_i;
    logic [31:0] PC_o;
    logic [31:0] IF_ID_PC_o;
    logic [31:0] IF_ID_PC_Plus4_o;
    logic [31:0] IF_ID_Instruction_o;
    logic        IF_ID_Valid_o;
    logic        Misaligned_o;
    logic [31:0] Fetch_Count_o;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .Stall_i             (Stall_i),
        .Redirect_i          (Redirect_i),
        .Target_i            (Target_i),
        .Instruction_i       (Instruction_i),
        .PC_o                (PC_o),
        .IF_ID_PC_o          (IF_ID_PC_o),
        .IF_ID_PC_Plus4_o    (IF_ID_PC_Plus4_o),
        .IF_ID_Instruction_o (IF_ID_Instruction_o),
        .IF_ID_Valid_o       (IF_ID_Valid_o),
        .Misaligned_o        (Misaligned_o),
        .Fetch_Count_o       (Fetch_Count_o)
    );

    always #5 clk = ~clk;

    assign Instruction_i = PC_o ^ 32'hA5A5_0000;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                               input logic [31:0] ip4, input logic [31:0] ins, input logic v,
                               input logic mis, input logic [31:0] cnt);
        check_eq({tag, ".pc"},    PC_o,                pc);
        check_eq({tag, ".ifpc"},  IF_ID_PC_o,          ipc);
        check_eq({tag, ".ifp4"},  IF_ID_PC_Plus4_o,    ip4);
        check_eq({tag, ".instr"}, IF_ID_Instruction_o, ins);
        check_eq({tag, ".valid"}, {31'd0, IF_ID_Valid_o}, {31'd0, v});
        check_eq({tag, ".mis"},   {31'd0, Misaligned_o},  {31'd0, mis});
        check_eq({tag, ".cnt"},   Fetch_Count_o,       cnt);
    endtask

    initial begin
        // reset wins over stall + misaligned redirect
        reset = 1'b1; Stall_i = 1'b1; Redirect_i = 1'b1; Target_i = 32'h0040_0102;
        step();
        check_state("rst", 32'h0040_0000, 32'h0, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 32'd0);

        reset = 1'b0; Stall_i = 1'b0; Redirect_i = 1'b0; Target_i = 32'h0;
        step();
        check_state("seq1", 32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 32'hA5E5_0000, 1'b1, 1'b0, 32'd1);
        step();
        check_state("seq2", 32'h0040_0008, 32'h0040_0004, 32'h0040_0008, 32'hA5E5_0004, 1'b1, 1'b0, 32'd2);

        Stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_state("stall", 32'h0040_0008, 32'h0040_0004, 32'h0040_0008, 32'hA5E5_0004, 1'b1, 1'b0, 32'd2);
        end
        Stall_i = 1'b0;
        step();
        check_state("seq3", 32'h0040_000C, 32'h0040_0008, 32'h0040_000C, 32'hA5E5_0008, 1'b1, 1'b0, 32'd3);

        Stall_i = 1'b1; Redirect_i = 1'b1; Target_i = 32'h0040_0100;
        step();
        check_state("rdst", 32'h0040_0100, 32'h0, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 32'd3);

        Stall_i = 1'b0; Target_i = 32'h0040_0102;
        step();
        check_state("mis", 32'h0040_0100, 32'h0, 32'h0, 32'h0000_0013, 1'b0, 1'b1, 32'd3);
        Redirect_i = 1'b0;
        step();
        check_state("mis_end", 32'h0040_0104, 32'h0040_0100, 32'h0040_0104, 32'hA5E5_0100, 1'b1, 1'b0, 32'd4);

        Redirect_i = 1'b1; Target_i = 32'h0000_0200;
        step();
        check_state("b2b1", 32'h0000_0200, 32'h0, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 32'd4);
        Target_i = 32'hFFFF_FFFC;
        step();
        check_state("b2b2", 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 32'd4);

        Redirect_i = 1'b0;
        step();
        check_state("wrap1", 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h5A5A_FFFC, 1'b1, 1'b0, 32'd5);
        step();
        check_state("wrap2", 32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 32'hA5A5_0000, 1'b1, 1'b0, 32'd6);

        reset = 1'b1; Stall_i = 1'b1; Redirect_i = 1'b1; Target_i = 32'h0040_0103;
        step();
        check_state("rst2", 32'h0040_0000, 32'h0, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 32'd0);

        reset = 1'b0; Stall_i = 1'b0; Redirect_i = 1'b0;
        step();
        check_state("post_rst", 32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 32'hA5E5_0000, 1'b1, 1'b0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
